rx_serial_7o1: RTL and testbench

- UART receiver for 7O1 frames: 1 start bit, 7 data bits sent LSB first, odd parity, 1 stop bit.
- It is the receive-side counterpart of the sonar's 7O1 transmitter. It lets a host send ASCII commands to the sonar, for example to start or pause a sweep.
- It samples each bit mid-period, checks parity and stop bit, and holds the received character until the consumer acknowledges it.

---
 rtl/rx_serial_7o1.sv | 157 +++++++++++++++
 tb/tb_rx_serial_7o1.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_serial_7o1.sv
// UART receiver for 7O1 frames: 1 start bit, 7 data bits LSB first, odd parity, 1 stop bit.
// Samples each bit mid-period and holds the character until the consumer acknowledges it.
module rx_serial_7o1 #(
    parameter int CLKS_PER_BIT = 434,
    parameter int N_CNT        = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       entrada_serial,
    input  logic       recebe_dado,
    output logic [6:0] dados_ascii,
    output logic       tem_dado,
    output logic       pronto,
    output logic       erro_paridade,
    output logic       erro_stop,
    output logic       erro_sobreposicao,
    output logic       db_tick,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        ESPERA   = 4'd0,
        INICIO   = 4'd1,
        DADOS    = 4'd2,
        PARIDADE = 4'd3,
        STOP     = 4'd4,
        ARMAZENA = 4'd5,
        QUEBRA   = 4'd6
    } state_t;

    localparam logic [N_CNT-1:0] HALF_LAST = N_CNT'(CLKS_PER_BIT / 2 - 1);
    localparam logic [N_CNT-1:0] BIT_LAST  = N_CNT'(CLKS_PER_BIT - 1);

    state_t           r_state;
    state_t           w_next;
    logic             r_sync1;
    logic             r_rx_s;
    logic [N_CNT-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [6:0]       r_shift;
    logic             r_parity;
    logic             r_stop;
    logic [6:0]       r_dados;
    logic             r_tem;
    logic             r_erp;
    logic             r_ers;
    logic             r_ovr;
    logic             w_tick;
    logic             w_half_done;
    logic             w_bit_done;

    assign w_half_done = (r_cnt == HALF_LAST);
    assign w_bit_done  = (r_cnt == BIT_LAST);

    // Synchronizer resets to 1 so the idle line is never mistaken for a start bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= entrada_serial;
            r_rx_s  <= r_sync1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= ESPERA;
        else        r_state <= w_next;
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    always_comb begin
        w_next = r_state;
        w_tick = 1'b0;
        case (r_state)
            ESPERA:   if (!r_rx_s) w_next = INICIO;
            INICIO:   if (w_half_done) begin
                          w_tick = 1'b1;
                          w_next = r_rx_s ? ESPERA : DADOS;
                      end
            DADOS:    if (w_bit_done) begin
                          w_tick = 1'b1;
                          if (r_bit_idx == 3'd6) w_next = PARIDADE;
                      end
            PARIDADE: if (w_bit_done) begin
                          w_tick = 1'b1;
                          w_next = STOP;
                      end
            STOP:     if (w_bit_done) begin
                          w_tick = 1'b1;
                          w_next = ARMAZENA;
                      end
            ARMAZENA: w_next = r_stop ? ESPERA : QUEBRA;
            QUEBRA:   if (r_rx_s) w_next = ESPERA;
            default:  w_next = ESPERA;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_stop    <= 1'b0;
        end else begin
            if (w_tick || r_state == ESPERA) r_cnt <= '0;
            else                             r_cnt <= r_cnt + N_CNT'(1);

            if (w_tick) begin
                case (r_state)
                    INICIO:   r_bit_idx <= '0;
                    DADOS: begin
                        r_shift   <= {r_rx_s, r_shift[6:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                    PARIDADE: r_parity <= r_rx_s;
                    STOP:     r_stop   <= r_rx_s;
                    default:  ;
                endcase
            end
        end
    end

    // A store in ARMAZENA takes priority over a simultaneous acknowledge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_dados <= '0;
            r_tem   <= 1'b0;
            r_erp   <= 1'b0;
            r_ers   <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (r_state == ARMAZENA) begin
            r_dados <= r_shift;
            r_erp   <= ~(^{r_shift, r_parity});
            r_ers   <= ~r_stop;
            r_tem   <= 1'b1;
            r_ovr   <= recebe_dado ? 1'b0 : (r_ovr | r_tem);
        end else if (recebe_dado && r_tem) begin
            r_tem <= 1'b0;
            r_erp <= 1'b0;
            r_ers <= 1'b0;
            r_ovr <= 1'b0;
        end
    end

    assign dados_ascii       = r_dados;
    assign tem_dado          = r_tem;
    assign erro_paridade     = r_erp;
    assign erro_stop         = r_ers;
    assign erro_sobreposicao = r_ovr;
    assign pronto            = (r_state == ARMAZENA);
    assign db_tick           = w_tick;
    assign db_estado         = r_state;

endmodule

// File: tb/tb_rx_serial_7o1.sv
// Directed bench for rx_serial_7o1 at 16 clocks per bit: framing, parity, break,
// glitch rejection, overrun, ack/store collision and mid-frame reset.
module tb_rx_serial_7o1;

    localparam int C = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       entrada_serial = 1'b1;
    logic       recebe_dado = 1'b0;
    logic [6:0] dados_ascii;
    logic       tem_dado, pronto, erro_paridade, erro_stop, erro_sobreposicao, db_tick;
    logic [3:0] db_estado;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int pronto_cnt = 0;
    int pronto_cyc = 0;
    int tick_cnt = 0;

    rx_serial_7o1 #(.CLKS_PER_BIT(C), .N_CNT(4)) dut (
        .clock             (clock),
        .reset             (reset),
        .entrada_serial    (entrada_serial),
        .recebe_dado       (recebe_dado),
        .dados_ascii       (dados_ascii),
        .tem_dado          (tem_dado),
        .pronto            (pronto),
        .erro_paridade     (erro_paridade),
        .erro_stop         (erro_stop),
        .erro_sobreposicao (erro_sobreposicao),
        .db_tick           (db_tick),
        .db_estado         (db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (pronto === 1'b1) begin
            pronto_cnt = pronto_cnt + 1;
            pronto_cyc = cyc;
        end
        if (db_tick === 1'b1) tick_cnt = tick_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drive_bit(input logic b);
        entrada_serial = b;
        repeat (C) @(negedge clock);
    endtask

    // Leaves the line at the stop-bit level; callers decide what follows.
    task automatic send_frame(input logic [6:0] d, input logic par, input logic stp);
        drive_bit(1'b0);
        for (int i = 0; i < 7; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stp);
    endtask

    task automatic ack;
        recebe_dado = 1'b1;
        @(negedge clock);
        recebe_dado = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        idle(3);
        vectors++;
        if ({dados_ascii, tem_dado, pronto, erro_paridade, erro_stop, erro_sobreposicao, db_tick, db_estado} !== 17'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h/%b%b%b%b%b%b/%0d required all zero", dados_ascii, tem_dado, pronto,
                     erro_paridade, erro_stop, erro_sobreposicao, db_tick, db_estado);
        end
        reset = 1'b1;
        idle(2 * C);
        vectors++;
        if (pronto_cnt !== 0 || db_estado !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_idle: pronto_cnt %0d state %0d required 0 and 0", pronto_cnt, db_estado);
        end
    endtask

    task automatic test_basic;
        int n0, t0, k0;
        n0 = pronto_cnt; t0 = cyc; k0 = tick_cnt;
        send_frame(7'h41, 1'b1, 1'b1);
        entrada_serial = 1'b1;
        idle(2 * C);
        vectors++;
        if (pronto_cnt - n0 !== 1) begin
            miscompares++;
            $display("FAIL basic_pronto_count: got %0d required 1", pronto_cnt - n0);
        end
        vectors++;
        if (pronto_cyc - t0 !== 155) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d required 155", pronto_cyc - t0);
        end
        vectors++;
        if (tick_cnt - k0 !== 10) begin
            miscompares++;
            $display("FAIL basic_ticks: got %0d required 10", tick_cnt - k0);
        end
        vectors++;
        if (dados_ascii !== 7'h41 || tem_dado !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_data: got %h tem %b required 41 tem 1", dados_ascii, tem_dado);
        end
        vectors++;
        if ({erro_paridade, erro_stop, erro_sobreposicao} !== 3'b000 || db_estado !== 4'd0) begin
            miscompares++;
            $display("FAIL basic_flags: got %b state %0d required 000 state 0",
                     {erro_paridade, erro_stop, erro_sobreposicao}, db_estado);
        end
        ack();
        vectors++;
        if (tem_dado !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_ack: tem_dado %b required 0", tem_dado);
        end
    endtask

    task automatic test_parity;
        send_frame(7'h41, 1'b0, 1'b1);
        entrada_serial = 1'b1;
        idle(2 * C);
        vectors++;
        if (dados_ascii !== 7'h41 || erro_paridade !== 1'b1 || tem_dado !== 1'b1 || erro_stop !== 1'b0) begin
            miscompares++;
            $display("FAIL parity_err: got %h perr %b tem %b serr %b required 41 1 1 0",
                     dados_ascii, erro_paridade, tem_dado, erro_stop);
        end
        ack();
        vectors++;
        if (tem_dado !== 1'b0 || erro_paridade !== 1'b0) begin
            miscompares++;
            $display("FAIL parity_ack: tem %b perr %b required 0 0", tem_dado, erro_paridade);
        end
    endtask

    task automatic test_break;
        int n0;
        n0 = pronto_cnt;
        send_frame(7'h23, 1'b0, 1'b0);
        repeat (40 * C) @(negedge clock);
        vectors++;
        if (db_estado !== 4'd6) begin
            miscompares++;
            $display("FAIL break_state: got %0d required 6", db_estado);
        end
        vectors++;
        if (dados_ascii !== 7'h23 || erro_stop !== 1'b1 || erro_paridade !== 1'b0 || pronto_cnt - n0 !== 1) begin
            miscompares++;
            $display("FAIL break_frame: got %h serr %b perr %b pulses %0d required 23 1 0 1",
                     dados_ascii, erro_stop, erro_paridade, pronto_cnt - n0);
        end
        entrada_serial = 1'b1;
        idle(4);
        vectors++;
        if (db_estado !== 4'd0) begin
            miscompares++;
            $display("FAIL break_release: state %0d required 0", db_estado);
        end
        idle(2 * C);
        vectors++;
        if (pronto_cnt - n0 !== 1) begin
            miscompares++;
            $display("FAIL break_single: pulses %0d required 1", pronto_cnt - n0);
        end
        ack();
    endtask

    task automatic test_glitch;
        int n0;
        n0 = pronto_cnt;
        entrada_serial = 1'b0;
        idle(4);
        entrada_serial = 1'b1;
        idle(3);
        vectors++;
        if (db_estado !== 4'd1) begin
            miscompares++;
            $display("FAIL glitch_inicio: state %0d required 1", db_estado);
        end
        idle(C);
        vectors++;
        if (db_estado !== 4'd0 || pronto_cnt !== n0 || dados_ascii !== 7'h23 || tem_dado !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_reject: state %0d pulses %0d data %h tem %b required 0 0 23 0",
                     db_estado, pronto_cnt - n0, dados_ascii, tem_dado);
        end
    endtask

    task automatic test_back_to_back;
        int  n0;
        bit  seen;
        n0 = pronto_cnt;
        send_frame(7'h31, 1'b0, 1'b1);
        send_frame(7'h2C, 1'b0, 1'b1);
        entrada_serial = 1'b1;
        idle(2 * C);
        vectors++;
        if (dados_ascii !== 7'h2C || erro_sobreposicao !== 1'b1 || tem_dado !== 1'b1 || pronto_cnt - n0 !== 2) begin
            miscompares++;
            $display("FAIL overrun: got %h ovr %b tem %b pulses %0d required 2c 1 1 2",
                     dados_ascii, erro_sobreposicao, tem_dado, pronto_cnt - n0);
        end
        ack();
        send_frame(7'h31, 1'b0, 1'b1);
        seen = 1'b0;
        fork
            send_frame(7'h2C, 1'b0, 1'b1);
            begin
                for (int i = 0; i < 12 * C && !seen; i++) begin
                    @(negedge clock);
                    if (db_estado === 4'd5) begin
                        seen = 1'b1;
                        ack();
                    end
                end
            end
        join
        entrada_serial = 1'b1;
        idle(2 * C);
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL collide_timeout: ARMAZENA not observed, seen %b required 1", seen);
        end
        vectors++;
        if (tem_dado !== 1'b1 || erro_sobreposicao !== 1'b0 || dados_ascii !== 7'h2C || erro_paridade !== 1'b0) begin
            miscompares++;
            $display("FAIL collide_store: tem %b ovr %b data %h perr %b required 1 0 2c 0",
                     tem_dado, erro_sobreposicao, dados_ascii, erro_paridade);
        end
    endtask

    task automatic test_reset_abort;
        int n0;
        logic [6:0] d;
        d = 7'h15;
        n0 = pronto_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        entrada_serial = d[3];
        idle(C / 2);
        reset = 1'b0;
        idle(3);
        vectors++;
        if ({dados_ascii, tem_dado, erro_paridade, erro_stop, erro_sobreposicao, db_estado} !== 15'h0) begin
            miscompares++;
            $display("FAIL abort_reset: data %h tem %b state %0d required 0 0 0", dados_ascii, tem_dado, db_estado);
        end
        reset = 1'b1;
        idle(C / 2 - 3);
        entrada_serial = 1'b1;
        idle(4 * C);
        vectors++;
        if (pronto_cnt !== n0 || db_estado !== 4'd0 || tem_dado !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_pronto: pulses %0d state %0d tem %b required 0 0 0",
                     pronto_cnt - n0, db_estado, tem_dado);
        end
        send_frame(7'h5A, 1'b1, 1'b1);
        entrada_serial = 1'b1;
        idle(2 * C);
        vectors++;
        if (dados_ascii !== 7'h5A || tem_dado !== 1'b1 || pronto_cnt - n0 !== 1) begin
            miscompares++;
            $display("FAIL abort_resume: data %h tem %b pulses %0d required 5a 1 1",
                     dados_ascii, tem_dado, pronto_cnt - n0);
        end
        vectors++;
        if ({erro_paridade, erro_stop, erro_sobreposicao} !== 3'b000) begin
            miscompares++;
            $display("FAIL abort_flags: got %b required 000", {erro_paridade, erro_stop, erro_sobreposicao});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_break();
        test_glitch();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
